inst_mem_loader: RTL and testbench

Instruction-memory responder for the fetch stage, with a byte-stream program loader on the write side. It stores program words written by a host byte stream and answers the fetch unit's word read requests. It asserts a hold to the core until a complete program, terminated by a halt word, has been loaded. It sits between the external boot/host link and the instruction fetch stage of the SimpleRISC pipeline.

---
 rtl/inst_mem_loader.sv | 219 +++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-stream program loader on the write side
// and a 1-cycle-latency word read port for the fetch stage. The core is held
// until a program terminated by a halt word has been fully loaded.
module inst_mem_loader #(
  parameter int          DEPTH   = 128,
  parameter int          ADDR_W  = 7,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_error,
  output logic [7:0]        load_count,
  output logic              core_hold,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        COUNT_MAX = 8'(DEPTH);

  state_t              state_r;
  state_t              next_state_s;

  logic [1:0]          byte_idx_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  // Only the three most recent bytes are ever needed to complete a word.
  logic [23:0]         asm_r;
  logic [7:0]          load_count_r;
  logic [31:0]         mem [DEPTH];

  logic                load_ready_r;
  logic                load_done_r;
  logic                load_error_r;
  logic                core_hold_r;
  logic [31:0]         rd_data_r;
  logic                rd_valid_r;

  logic                load_ready_s;
  logic                load_done_s;
  logic                load_error_s;
  logic                core_hold_s;

  logic                accept_s;
  logic                word_done_s;
  logic [31:0]         word_s;
  logic                load_entry_s;

  // A word ends the load when its opcode field is the halt opcode.
  function automatic logic is_halt(input logic [31:0] w);
    return (w[31:27] == HALT_OP);
  endfunction

  assign accept_s     = (state_r == ST_LOAD) && load_valid;
  assign word_done_s  = accept_s && (byte_idx_r == 2'd3);
  assign word_s       = {asm_r, load_byte};
  assign load_entry_s = (next_state_s == ST_LOAD) && (state_r != ST_LOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; load_start is deliberately ignored while loading.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_done_s) begin
          if (is_halt(word_s)) begin
            next_state_s = ST_READY;
          end else if (wr_ptr_r == LAST_ADDR) begin
            next_state_s = ST_ERROR;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_READY, ST_ERROR: begin
        if (load_start) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    load_ready_s = 1'b0;
    load_done_s  = 1'b0;
    load_error_s = 1'b0;
    core_hold_s  = 1'b1;
    case (next_state_s)
      ST_IDLE: begin
        core_hold_s = 1'b1;
      end
      ST_LOAD: begin
        load_ready_s = 1'b1;
      end
      ST_READY: begin
        load_done_s = 1'b1;
        core_hold_s = 1'b0;
      end
      ST_ERROR: begin
        load_error_s = 1'b1;
      end
      default: begin
        core_hold_s = 1'b1;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
      core_hold_r  <= 1'b1;
    end else begin
      load_ready_r <= load_ready_s;
      load_done_r  <= load_done_s;
      load_error_r <= load_error_s;
      core_hold_r  <= core_hold_s;
    end
  end

  // Byte assembly, write pointer and saturating word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_r   <= 2'd0;
      wr_ptr_r     <= '0;
      asm_r        <= 24'd0;
      load_count_r <= 8'd0;
    end else if (load_entry_s) begin
      byte_idx_r   <= 2'd0;
      wr_ptr_r     <= '0;
      load_count_r <= 8'd0;
    end else if (accept_s) begin
      asm_r <= word_s[23:0];
      if (byte_idx_r == 2'd3) begin
        byte_idx_r <= 2'd0;
        wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
        if (load_count_r != COUNT_MAX) begin
          load_count_r <= load_count_r + 8'd1;
        end else begin
          load_count_r <= load_count_r;
        end
      end else begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end
    end else begin
      byte_idx_r <= byte_idx_r;
    end
  end

  // Program storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (word_done_s) begin
      mem[wr_ptr_r] <= word_s;
    end
  end

  // Fetch read port: served only when a program is loaded, data held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      if (state_r == ST_READY) begin
        rd_data_r  <= mem[rd_addr];
        rd_valid_r <= 1'b1;
      end else begin
        rd_data_r  <= 32'd0;
        rd_valid_r <= 1'b0;
      end
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign load_ready = load_ready_r;
  assign load_done  = load_done_r;
  assign load_error = load_error_r;
  assign load_count = load_count_r;
  assign core_hold  = core_hold_r;
  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader with a word-level
// reference model of the loaded program image.
module tb_inst_mem_loader;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic [7:0]  load_count;
  logic        core_hold;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  inst_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_error (load_error),
    .load_count (load_count),
    .core_hold  (core_hold),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: program image plus the outcome of the current load.
  logic [31:0] ref_mem [DEPTH];
  int          exp_count;
  bit          exp_done;
  bit          exp_err;
  bit          load_over;
  logic [31:0] prog [$];
  logic [31:0] last_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model of one word leaving the byte stream: stored in order, ends on halt or a full memory.
  task automatic model_write(input logic [31:0] w);
    if (!load_over) begin
      ref_mem[exp_count] = w;
      exp_count++;
      if (w[31:27] == 5'b11111) begin
        exp_done  = 1'b1;
        load_over = 1'b1;
      end else if (exp_count == DEPTH) begin
        exp_err   = 1'b1;
        load_over = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] rand_body();
    logic [31:0] w;
    w = $urandom();
    if (w[31:27] == 5'b11111) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] rand_halt();
    logic [31:0] w;
    w = $urandom();
    w[31:27] = 5'b11111;
    return w;
  endfunction

  task automatic build_prog(input int nbody, input bit with_halt);
    prog.delete();
    for (int i = 0; i < nbody; i++) prog.push_back(rand_body());
    if (with_halt) prog.push_back(rand_halt());
  endtask

  // gaps: 0 = none, 1 = random idle cycles with stray load_start, 2 = strict valid toggling.
  task automatic send_byte(input logic [7:0] b, input int gaps);
    int n;
    n = (gaps == 2) ? 1 : ((gaps == 1) ? $urandom_range(0, 2) : 0);
    for (int g = 0; g < n; g++) begin
      load_valid = 1'b0;
      load_start = (gaps == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      load_start = 1'b0;
    end
    load_valid = 1'b1;
    load_byte  = b;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gaps);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24], gaps);
    send_byte(t[23:16], gaps);
    send_byte(t[15:8],  gaps);
    send_byte(t[7:0],   gaps);
    model_write(w);
  endtask

  task automatic model_start();
    exp_count = 0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    load_over = 1'b0;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    model_start();
    check_val("start_hold",  {31'd0, core_hold},  32'd1);
    check_val("start_ready", {31'd0, load_ready}, 32'd1);
  endtask

  task automatic stream_prog(input int gaps);
    foreach (prog[i]) send_word(prog[i], gaps);
  endtask

  task automatic check_outcome(input string tag);
    check_val({tag, "_done"},  {31'd0, load_done},  {31'd0, exp_done});
    check_val({tag, "_err"},   {31'd0, load_error}, {31'd0, exp_err});
    check_val({tag, "_hold"},  {31'd0, core_hold},  {31'd0, !exp_done});
    check_val({tag, "_count"}, {24'd0, load_count}, 32'(exp_count));
    check_val({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
  endtask

  // Back-to-back reads; only a loaded program answers, otherwise zero data and no valid.
  task automatic read_burst(input int n, input bit seq);
    int a;
    for (int k = 0; k < n; k++) begin
      if (exp_done) a = seq ? k : $urandom_range(0, exp_count - 1);
      else          a = $urandom_range(0, DEPTH - 1);
      rd_en   = 1'b1;
      rd_addr = 7'(a);
      cyc();
      last_rd = exp_done ? ref_mem[a] : 32'd0;
      check_val("rd_valid", {31'd0, rd_valid}, {31'd0, exp_done});
      check_val("rd_data",  rd_data, last_rd);
    end
    rd_en = 1'b0;
    cyc();
    check_val("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rd_idle_hold",  rd_data, last_rd);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'd0;
    rd_en = 1'b0; rd_addr = 7'd0;
    model_start();
    cyc(); cyc();
    rst = 1'b0;
    check_val("rst_hold",  {31'd0, core_hold},  32'd1);
    check_val("rst_done",  {31'd0, load_done},  32'd0);
    check_val("rst_err",   {31'd0, load_error}, 32'd0);
    check_val("rst_ready", {31'd0, load_ready}, 32'd0);
    check_val("rst_count", {24'd0, load_count}, 32'd0);
    rd_en = 1'b1; rd_addr = 7'd0;
    cyc();
    rd_en = 1'b0;
    check_val("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("idle_rd_data",  rd_data, 32'd0);

    // Basic load from the directed byte sequence, then sequential readback.
    prog.delete();
    prog.push_back(32'h12345678);
    prog.push_back(32'h0000002A);
    prog.push_back(32'hF8000000);
    do_start();
    stream_prog(0);
    check_outcome("basic");
    read_burst(3, 1'b1);

    // Same program with valid toggling every cycle.
    do_start();
    stream_prog(2);
    check_outcome("gapped");
    read_burst(3, 1'b1);

    // Random programs with random gaps and stray load_start pulses mid-load.
    for (int t = 0; t < 6; t++) begin
      build_prog($urandom_range(0, 20), 1'b1);
      do_start();
      stream_prog(1);
      check_outcome("rand");
      read_burst(4, 1'b0);
    end

    // Restart from READY with a read in the same cycle: the read is still served.
    build_prog(3, 1'b1);
    rd_en = 1'b1; rd_addr = 7'd1; load_start = 1'b1;
    last_rd = ref_mem[1];
    cyc();
    rd_en = 1'b0; load_start = 1'b0;
    check_val("restart_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_val("restart_rd_data",  rd_data, last_rd);
    check_val("restart_hold",     {31'd0, core_hold}, 32'd1);
    model_start();
    stream_prog(0);
    check_outcome("restart");
    read_burst(4, 1'b1);

    // Overflow: a full memory without a halt word.
    build_prog(DEPTH, 1'b0);
    do_start();
    stream_prog(0);
    check_outcome("ovf");
    read_burst(2, 1'b0);
    build_prog(0, 1'b1);
    do_start();
    stream_prog(0);
    check_outcome("after_ovf");
    read_burst(1, 1'b1);

    // Reset mid-word, then a fresh load must restart at address 0 and byte 0.
    build_prog(1, 1'b0);
    do_start();
    stream_prog(1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_start();
    check_outcome("midrst");
    build_prog($urandom_range(1, 6), 1'b1);
    do_start();
    stream_prog(1);
    check_outcome("post_rst");
    read_burst(exp_count, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
